regfile_dump_reader: RTL

REGFILE_DUMP_READER -- requirements
Module: regfile_dump_reader

---
 rtl/regfile_dump_reader.sv | 120 ++++++++++++
 1 files changed

// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader: streams a 2-read-port regfile out, one pair per fetch.
// Ports: clk, reset (sync, high); start, abort control; rdAddrA/B and
// rdDataA/B to the regfile; out_valid/out_ready/out_data/out_index/out_last
// valid-ready stream; busy while not IDLE; done pulses after the last word.
module regfile_dump_reader #(
  parameter int NUM_REGS = 32,
  parameter int DATA_W   = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  output logic [4:0]        rdAddrA,
  output logic [4:0]        rdAddrB,
  input  logic [DATA_W-1:0] rdDataA,
  input  logic [DATA_W-1:0] rdDataB,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [4:0]        out_index,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam logic [3:0] KLAST = 4'(NUM_REGS / 2 - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SEND_A,
    SEND_B,
    DONE
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [3:0]        k_q;
  logic [3:0]        k_d;
  logic [DATA_W-1:0] hold_a;
  logic [DATA_W-1:0] hold_b;

  assign rdAddrA = {k_q, 1'b0};
  assign rdAddrB = {k_q, 1'b1};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      k_q     <= '0;
      hold_a  <= '0;
      hold_b  <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      if (state_q == FETCH) begin
        hold_a <= rdDataA;
        hold_b <= rdDataB;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    out_valid = 1'b0;
    out_data  = '0;
    out_index = '0;
    out_last  = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    unique case (state_q)
      IDLE: begin
        busy = 1'b0;
        // abort wins over a simultaneous start
        if (start && !abort) begin
          state_d = FETCH;
          k_d     = '0;
        end
      end
      FETCH: begin
        state_d = SEND_A;
      end
      SEND_A: begin
        out_valid = 1'b1;
        out_data  = hold_a;
        out_index = {k_q, 1'b0};
        if (out_ready) begin
          state_d = SEND_B;
        end
      end
      SEND_B: begin
        out_valid = 1'b1;
        out_data  = hold_b;
        out_index = {k_q, 1'b1};
        out_last  = (k_q == KLAST);
        if (out_ready) begin
          if (k_q == KLAST) begin
            state_d = DONE;
          end else begin
            k_d     = k_q + 4'd1;
            state_d = FETCH;
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (abort && (state_q == FETCH || state_q == SEND_A ||
                  state_q == SEND_B)) begin
      state_d = IDLE;
      k_d     = '0;
    end
  end

endmodule
